kfxt_scancode_translator: RTL and testbench



---
 rtl/kfxt_scancode_translator.sv | 228 ++++++++++++++++++++++
 tb/tb_kfxt_scancode_translator.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kfxt_scancode_translator.sv
// PS/2 scan-code set 2 to IBM PC/XT set 1 translator with output FIFO and XT holding register.
// Optional: define KFXT_FAKE_SHIFT_FILTER_EN to drop the E0-prefixed fake-shift codes (12, 59).
module kfxt_scancode_translator #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] ps2_code,
    input  logic       ps2_code_valid,
    input  logic       clear_keycode,
    output logic [7:0] xt_keycode,
    output logic       xt_irq,
    output logic       overflow
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_M2 = CW'(FIFO_DEPTH - 2);

    // i8042 set-2 -> set-1 translation for codes 00-7F (entry 00 is never used).
    localparam logic [0:127][7:0] XLAT = {
        8'hFF, 8'h43, 8'h41, 8'h3F, 8'h3D, 8'h3B, 8'h3C, 8'h58,
        8'h64, 8'h44, 8'h42, 8'h40, 8'h3E, 8'h0F, 8'h29, 8'h59,
        8'h65, 8'h38, 8'h2A, 8'h70, 8'h1D, 8'h10, 8'h02, 8'h5A,
        8'h66, 8'h71, 8'h2C, 8'h1F, 8'h1E, 8'h11, 8'h03, 8'h5B,
        8'h67, 8'h2E, 8'h2D, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5C,
        8'h68, 8'h39, 8'h2F, 8'h21, 8'h14, 8'h13, 8'h06, 8'h5D,
        8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5E,
        8'h6A, 8'h72, 8'h32, 8'h24, 8'h16, 8'h08, 8'h09, 8'h5F,
        8'h6B, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0B, 8'h0A, 8'h60,
        8'h6C, 8'h34, 8'h35, 8'h26, 8'h27, 8'h19, 8'h0C, 8'h61,
        8'h6D, 8'h73, 8'h28, 8'h74, 8'h1A, 8'h0D, 8'h62, 8'h6E,
        8'h3A, 8'h36, 8'h1C, 8'h1B, 8'h75, 8'h2B, 8'h63, 8'h76,
        8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7A, 8'h0E, 8'h7B,
        8'h7C, 8'h4F, 8'h7D, 8'h4B, 8'h47, 8'h7E, 8'h7F, 8'h6F,
        8'h52, 8'h53, 8'h50, 8'h4C, 8'h4D, 8'h48, 8'h01, 8'h45,
        8'h57, 8'h4E, 8'h51, 8'h4A, 8'h37, 8'h49, 8'h46, 8'h54
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    // Returns {mapped, set1_code}.
    function automatic logic [8:0] xlat(input logic [7:0] code);
        logic [8:0] r;
        r = '0;
        if (code == 8'h83) begin
            r = {1'b1, 8'h41};
        end else if (!code[7] && (code != 8'h00)) begin
            r = {1'b1, XLAT[code[6:0]]};
        end
        return r;
    endfunction

    function automatic logic is_passthru(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) ||
               (code == 8'hFE) || (code == 8'hFC) || (code == 8'h00) ||
               (code == 8'hFF);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] code);
`ifdef KFXT_FAKE_SHIFT_FILTER_EN
        return (code == 8'h12) || (code == 8'h59);
`else
        return (code == 8'hFF) && (code == 8'h00);
`endif
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     stg_cnt_q, stg_cnt_d;
    logic [7:0]     stg_b0_q, stg_b0_d;
    logic [7:0]     stg_b1_q, stg_b1_d;
    logic           tail_vld_q, tail_vld_d;
    logic [7:0]     tail_byte_q, tail_byte_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     key_q, key_d;
    logic           irq_q, irq_d;
    logic           ovf_q, ovf_d;
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic [8:0]     tr;
    logic           push;
    logic [7:0]     push_byte;
    logic           pop;

    // Prefix decoder: stages zero, one or two bytes for the FIFO on the cycle after the strobe.
    always_comb begin
        state_d   = state_q;
        stg_cnt_d = 2'd0;
        stg_b0_d  = stg_b0_q;
        stg_b1_d  = stg_b1_q;
        tr        = xlat(ps2_code);
        if (ps2_code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_code == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (ps2_code == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if ((ps2_code == 8'hE1) || is_passthru(ps2_code)) begin
                        stg_cnt_d = 2'd1;
                        stg_b0_d  = ps2_code;
                    end else if (tr[8]) begin
                        stg_cnt_d = 2'd1;
                        stg_b0_d  = tr[7:0];
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (tr[8]) begin
                        stg_cnt_d = 2'd1;
                        stg_b0_d  = tr[7:0] | 8'h80;
                    end
                end
                ST_EXT: begin
                    if (ps2_code == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (tr[8] && !is_fake_shift(ps2_code)) begin
                            stg_cnt_d = 2'd2;
                            stg_b0_d  = 8'hE0;
                            stg_b1_d  = tr[7:0];
                        end
                    end
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (tr[8] && !is_fake_shift(ps2_code)) begin
                        stg_cnt_d = 2'd2;
                        stg_b0_d  = 8'hE0;
                        stg_b1_d  = tr[7:0] | 8'h80;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // E0 pairs reserve two slots up front, so the trailing byte never needs a space check.
    always_comb begin
        push        = 1'b0;
        push_byte   = stg_b0_q;
        tail_vld_d  = 1'b0;
        tail_byte_d = tail_byte_q;
        ovf_d       = ovf_q;
        if (tail_vld_q) begin
            push      = 1'b1;
            push_byte = tail_byte_q;
        end else if (stg_cnt_q == 2'd1) begin
            if (count_q < DEPTH_C) begin
                push = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (stg_cnt_q == 2'd2) begin
            if (count_q <= DEPTH_M2) begin
                push        = 1'b1;
                tail_vld_d  = 1'b1;
                tail_byte_d = stg_b1_q;
            end else begin
                ovf_d = 1'b1;
            end
        end

        pop   = !irq_q && !clear_keycode && (count_q != '0);
        key_d = key_q;
        irq_d = irq_q;
        if (clear_keycode) begin
            key_d = '0;
            irq_d = 1'b0;
        end else if (pop) begin
            key_d = mem_q[rd_ptr_q];
            irq_d = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            stg_cnt_q   <= 2'd0;
            stg_b0_q    <= '0;
            stg_b1_q    <= '0;
            tail_vld_q  <= 1'b0;
            tail_byte_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            key_q       <= '0;
            irq_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stg_cnt_q   <= stg_cnt_d;
            stg_b0_q    <= stg_b0_d;
            stg_b1_q    <= stg_b1_d;
            tail_vld_q  <= tail_vld_d;
            tail_byte_q <= tail_byte_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            key_q       <= key_d;
            irq_q       <= irq_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    assign xt_keycode = key_q;
    assign xt_irq     = irq_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_kfxt_scancode_translator.sv
// Directed self-checking bench for kfxt_scancode_translator (FIFO_DEPTH = 8).
module tb_kfxt_scancode_translator;
    logic       clock;
    logic       reset_n;
    logic [7:0] ps2_code;
    logic       ps2_code_valid;
    logic       clear_keycode;
    logic [7:0] xt_keycode;
    logic       xt_irq;
    logic       overflow;

    int n_checks;
    int n_fail;

    kfxt_scancode_translator #(.FIFO_DEPTH(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ps2_code       (ps2_code),
        .ps2_code_valid (ps2_code_valid),
        .clear_keycode  (clear_keycode),
        .xt_keycode     (xt_keycode),
        .xt_irq         (xt_irq),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle strobe, then a quiet gap of 'gap' cycles; returns at the negedge after the sampling edge (+gap).
    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clock);
        ps2_code       = b;
        ps2_code_valid = 1'b1;
        @(negedge clock);
        ps2_code_valid = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    // Waits (bounded) for xt_irq, captures the byte, then acknowledges with one clear pulse.
    task automatic pop_byte(output logic [7:0] b, output bit got);
        got = 1'b0;
        b   = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (xt_irq) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (got) begin
            b = xt_keycode;
            clear_keycode = 1'b1;
            @(negedge clock);
            clear_keycode = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({xt_keycode, xt_irq, overflow} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got key=%02h irq=%0b ovf=%0b, want 00/0/0", xt_keycode, xt_irq, overflow);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_make_break;
        logic [7:0] b;
        bit got;
        send(8'h1C, 0);
        @(negedge clock);
        n_checks++;
        if (xt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL make_latency_early: irq=%0b at N+1, want 0", xt_irq);
        end
        @(negedge clock);
        n_checks++;
        if ({xt_keycode, xt_irq} !== {8'h1E, 1'b1}) begin
            n_fail++;
            $display("FAIL make_1c: got key=%02h irq=%0b, want 1E/1", xt_keycode, xt_irq);
        end
        clear_keycode = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({xt_keycode, xt_irq} !== {8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_pulse: got key=%02h irq=%0b, want 00/0", xt_keycode, xt_irq);
        end
        clear_keycode = 1'b0;
        send(8'hF0, 4);
        send(8'h1C, 4);
        pop_byte(b, got);
        n_checks++;
        if (!got || b !== 8'h9E) begin
            n_fail++;
            $display("FAIL break_1c: got=%0b key=%02h, want 9E", got, b);
        end
    endtask

    task automatic test_extended;
        logic [7:0] b;
        bit got;
        send(8'hE0, 4);
        send(8'hF0, 4);
        send(8'h75, 0);
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if ({xt_keycode, xt_irq} !== {8'hE0, 1'b1}) begin
            n_fail++;
            $display("FAIL ext_prefix_first: got key=%02h irq=%0b, want E0/1", xt_keycode, xt_irq);
        end
        pop_byte(b, got);
        pop_byte(b, got);
        n_checks++;
        if (!got || b !== 8'hC8) begin
            n_fail++;
            $display("FAIL ext_break_75: got=%0b key=%02h, want C8", got, b);
        end
        pop_byte(b, got);
        n_checks++;
        if (got) begin
            n_fail++;
            $display("FAIL ext_no_extra: got extra byte %02h, want none", b);
        end
    endtask

    task automatic test_passthru_and_83;
        logic [7:0] exp [3];
        logic [7:0] b;
        bit got;
        exp[0] = 8'hAA; exp[1] = 8'h41; exp[2] = 8'hC1;
        send(8'hAA, 4);
        send(8'h83, 4);
        send(8'h90, 4);
        send(8'hF0, 4);
        send(8'h83, 4);
        for (int i = 0; i < 3; i++) begin
            pop_byte(b, got);
            n_checks++;
            if (!got || b !== exp[i]) begin
                n_fail++;
                $display("FAIL passthru_seq[%0d]: got=%0b key=%02h, want %02h", i, got, b, exp[i]);
            end
        end
        pop_byte(b, got);
        n_checks++;
        if (got) begin
            n_fail++;
            $display("FAIL unmapped_no_push: got byte %02h, want none", b);
        end
    endtask

    task automatic test_clear_held_accepts;
        logic [7:0] b;
        bit got;
        clear_keycode = 1'b1;
        send(8'h5A, 6);
        n_checks++;
        if ({xt_keycode, xt_irq} !== {8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_blocks_load: got key=%02h irq=%0b, want 00/0", xt_keycode, xt_irq);
        end
        clear_keycode = 1'b0;
        pop_byte(b, got);
        n_checks++;
        if (!got || b !== 8'h1C) begin
            n_fail++;
            $display("FAIL clear_held_accept: got=%0b key=%02h, want 1C", got, b);
        end
    endtask

    task automatic test_pause;
        logic [7:0] seq [8];
        logic [7:0] exp [6];
        logic [7:0] b;
        bit got;
        seq[0] = 8'hE1; seq[1] = 8'h14; seq[2] = 8'h77; seq[3] = 8'hE1;
        seq[4] = 8'hF0; seq[5] = 8'h14; seq[6] = 8'hF0; seq[7] = 8'h77;
        exp[0] = 8'hE1; exp[1] = 8'h1D; exp[2] = 8'h45;
        exp[3] = 8'hE1; exp[4] = 8'h9D; exp[5] = 8'hC5;
        for (int i = 0; i < 8; i++) send(seq[i], 4);
        for (int i = 0; i < 6; i++) begin
            pop_byte(b, got);
            n_checks++;
            if (!got || b !== exp[i]) begin
                n_fail++;
                $display("FAIL pause[%0d]: got=%0b key=%02h, want %02h", i, got, b, exp[i]);
            end
        end
    endtask

    task automatic test_fake_shift;
        logic [7:0] b;
        bit got;
        send(8'hE0, 4);
        send(8'h12, 6);
`ifdef KFXT_FAKE_SHIFT_FILTER_EN
        n_checks++;
        if (xt_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL fake_shift_filtered: irq=%0b key=%02h, want 0", xt_irq, xt_keycode);
        end
        pop_byte(b, got);
        n_checks++;
        if (got) begin
            n_fail++;
            $display("FAIL fake_shift_no_push: got byte %02h, want none", b);
        end
`else
        pop_byte(b, got);
        n_checks++;
        if (!got || b !== 8'hE0) begin
            n_fail++;
            $display("FAIL fake_shift_e0: got=%0b key=%02h, want E0", got, b);
        end
        pop_byte(b, got);
        n_checks++;
        if (!got || b !== 8'h2A) begin
            n_fail++;
            $display("FAIL fake_shift_2a: got=%0b key=%02h, want 2A", got, b);
        end
`endif
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fake_shift_ovf: overflow=%0b, want 0", overflow);
        end
    endtask

    // Holding + 8 FIFO slots = 9 bytes of capacity.
    task automatic test_overflow;
        logic [7:0] b;
        bit got;
        for (int i = 0; i < 8; i++) send(8'h76, 4);
        n_checks++;
        if ({xt_keycode, xt_irq, overflow} !== {8'h01, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_8: got key=%02h irq=%0b ovf=%0b, want 01/1/0", xt_keycode, xt_irq, overflow);
        end
        send(8'hE0, 4);
        send(8'h75, 4);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_atomic_drop_ovf: overflow=%0b, want 1", overflow);
        end
        send(8'h76, 4);
        send(8'h76, 4);
        for (int i = 0; i < 9; i++) begin
            pop_byte(b, got);
            n_checks++;
            if (!got || b !== 8'h01) begin
                n_fail++;
                $display("FAIL drain[%0d]: got=%0b key=%02h, want 01", i, got, b);
            end
        end
        pop_byte(b, got);
        n_checks++;
        if (got) begin
            n_fail++;
            $display("FAIL drain_extra: got byte %02h, want none", b);
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: overflow=%0b, want 1", overflow);
        end
    endtask

    task automatic test_reset_mid_sequence;
        logic [7:0] b;
        bit got;
        send(8'h76, 4);
        send(8'h76, 4);
        send(8'hF0, 2);
        reset_n = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({xt_keycode, xt_irq, overflow} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got key=%02h irq=%0b ovf=%0b, want 00/0/0", xt_keycode, xt_irq, overflow);
        end
        reset_n = 1'b1;
        @(negedge clock);
        send(8'h5A, 4);
        pop_byte(b, got);
        n_checks++;
        if (!got || b !== 8'h1C) begin
            n_fail++;
            $display("FAIL post_reset_make: got=%0b key=%02h, want 1C", got, b);
        end
        pop_byte(b, got);
        n_checks++;
        if (got) begin
            n_fail++;
            $display("FAIL post_reset_fifo_empty: got byte %02h, want none", b);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        ps2_code       = 8'h00;
        ps2_code_valid = 1'b0;
        clear_keycode  = 1'b0;
        test_reset;
        test_make_break;
        test_extended;
        test_passthru_and_83;
        test_clear_held_accepts;
        test_pause;
        test_fake_shift;
        test_overflow;
        test_reset_mid_sequence;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
